// File: rtl/is_pkg_uart_controller.sv
// ---------------------------------------------------------------------------
// is_pkg_uart_controller
// Shared definitions for the UART controller transmit and receive FSMs.
//   state_t         : frame-sequencing states of the transmitter
//   parity_t        : parity bit source selection
//   UART_DATA_W     : payload width of one character
//   UART_IDLE_LVL   : line level while no frame is being sent
//   uart_parity()   : parity bit for a character, used by TX and RX
// ---------------------------------------------------------------------------
package is_pkg_uart_controller;

    localparam int unsigned UART_DATA_W   = 8;
    localparam logic        UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TSTRB = 3'd1,
        TDT   = 3'd2,
        TPARB = 3'd3,
        TSTB1 = 3'd4,
        TSTB2 = 3'd5,
        TEND  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_ODD   = 3'd1,
        PAR_EVEN  = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_t;

    // Parity bit for one character; PAR_NONE yields 0 (bit is not sent).
    function automatic logic uart_parity(input parity_t                mode,
                                         input logic [UART_DATA_W-1:0] data);
        logic w_par;
        w_par = 1'b0;
        case (mode)
            PAR_ODD:  w_par = ~^data;
            PAR_EVEN: w_par = ^data;
            PAR_MARK: w_par = 1'b1;
            default:  w_par = 1'b0;
        endcase
        return w_par;
    endfunction

endpackage

// File: rtl/is_uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// is_uart_tx_fsm
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// STOP_BITS stop bits. One bit is emitted per tx_ce_i strobe.
//
// Parameters
//   PARITY_MODE  : parity bit source (PAR_NONE/ODD/EVEN/MARK/SPACE)
//   STOP_BITS    : number of stop bits, 1 or 2
// Ports
//   clk_i         in   system clock
//   rst_i         in   synchronous active-high reset
//   tx_ce_i       in   bit-rate enable strobe, one per bit period
//   tx_data_en_i  in   host request, tx_data_i valid
//   tx_data_i     in   byte to send
//   txd_o         out  serial line, registered, idle high
//   txct_r_o      out  ready, 1 = idle and able to accept a byte
//   tx_done_o     out  one-cycle pulse at the end of the last stop bit
// ---------------------------------------------------------------------------
module is_uart_tx_fsm
    import is_pkg_uart_controller::*;
#(
    parameter parity_t     PARITY_MODE = PAR_SPACE,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   tx_ce_i,
    input  logic                   tx_data_en_i,
    input  logic [UART_DATA_W-1:0] tx_data_i,
    output logic                   txd_o,
    output logic                   txct_r_o,
    output logic                   tx_done_o
);

    localparam int unsigned CNT_W = 3;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [UART_DATA_W-1:0] r_shreg;
    logic                   r_par;
    logic                   r_txd;
    logic                   r_rdy;
    logic                   r_done;

    // The tx_done_o cycle is never an acceptance cycle, so a host holding
    // tx_data_en_i high gets its next byte taken in the cycle after the pulse.
    logic w_accept;
    assign w_accept = tx_data_en_i & r_rdy & ~r_done;

    // Frame sequencer; every state after IDLE advances only on a strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_par   <= 1'b0;
            r_txd   <= UART_IDLE_LVL;
            r_rdy   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A strobe coinciding with acceptance is not used for
                    // the start bit; the start bit waits for the next strobe.
                    if (w_accept) begin
                        r_shreg <= tx_data_i;
                        r_par   <= uart_parity(PARITY_MODE, tx_data_i);
                        r_rdy   <= 1'b0;
                        r_state <= TSTRB;
                    end
                end
                TSTRB: begin
                    if (tx_ce_i) begin
                        r_txd   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= TDT;
                    end
                end
                TDT: begin
                    if (tx_ce_i) begin
                        r_txd   <= r_shreg[0];
                        r_shreg <= {1'b0, r_shreg[UART_DATA_W-1:1]};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        // Counter at 7 means the 8th data bit is going out now.
                        if (r_cnt == CNT_W'(7)) begin
                            r_state <= (PARITY_MODE != PAR_NONE) ? TPARB : TSTB1;
                        end
                    end
                end
                TPARB: begin
                    if (tx_ce_i) begin
                        r_txd   <= r_par;
                        r_state <= TSTB1;
                    end
                end
                TSTB1: begin
                    if (tx_ce_i) begin
                        r_txd   <= 1'b1;
                        r_state <= (STOP_BITS == 2) ? TSTB2 : TEND;
                    end
                end
                TSTB2: begin
                    if (tx_ce_i) begin
                        r_txd   <= 1'b1;
                        r_state <= TEND;
                    end
                end
                TEND: begin
                    // Strobe here closes the last stop bit period.
                    if (tx_ce_i) begin
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_txd   <= UART_IDLE_LVL;
                    r_rdy   <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign txd_o     = r_txd;
    assign txct_r_o  = r_rdy;
    assign tx_done_o = r_done;

endmodule

// File: tb/tb_is_uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// tb_is_uart_tx_fsm
// Five transmitter instances (different parity / stop-bit settings) share
// clock, reset, strobe and host stimulus. Each instance has a reference model
// that decides acceptance, pushes the expected frame bit list into a queue,
// and a monitor that pops and compares it against the serial line.
// ---------------------------------------------------------------------------
module tb_is_uart_tx_fsm;
    import is_pkg_uart_controller::*;

    localparam int NI = 5;
    localparam parity_t     CFG_PAR  [NI] = '{PAR_SPACE, PAR_ODD, PAR_EVEN, PAR_MARK, PAR_NONE};
    localparam int unsigned CFG_STOP [NI] = '{2, 1, 2, 1, 2};

    typedef struct {
        logic [11:0] bits;
        int          n;
        int          start;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce  = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] data = 8'h00;

    logic       rst_q  = 1'b1;
    logic       ce_q   = 1'b0;
    logic       en_q   = 1'b0;
    logic [7:0] data_q = 8'h00;

    logic txd_w  [NI];
    logic rdy_w  [NI];
    logic done_w [NI];

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    int  ce_mode = 0;
    int  div = 0;
    bit  b2b_on = 1'b0;
    int  last_done_a [NI];
    bit  busy_a      [NI];
    int  q_size_a    [NI];
    int  n_acc_a     [NI];
    int  n_done_a    [NI];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_q  <= rst;
        ce_q   <= ce;
        en_q   <= en;
        data_q <= data;
    end

    // Strobe generator: every 16 clocks, stuck high, or random.
    always @(posedge clk) begin
        #1;
        case (ce_mode)
            0: begin
                div = (div == 15) ? 0 : div + 1;
                ce  = (div == 15);
            end
            1:       ce = 1'b1;
            default: ce = ($urandom_range(2) == 0);
        endcase
    end

    task automatic check(input int inst, input string name,
                         input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL u%0d %s @cyc %0d: got %0h expected %0h", inst, name, cyc, got, exp);
        end
    endtask

    // Frame as the line should carry it, from the frame format rules.
    function automatic frame_t make_frame(input logic [7:0] d, input parity_t pm,
                                          input int unsigned sb);
        frame_t f;
        int     k;
        int     ones;
        f.bits  = '1;
        f.start = 0;
        k       = 0;
        ones    = $countones(d);
        f.bits[k] = 1'b0;
        k++;
        for (int i = 0; i < 8; i++) begin
            f.bits[k] = d[i];
            k++;
        end
        if (pm != PAR_NONE) begin
            case (pm)
                PAR_ODD:  f.bits[k] = 1'((ones % 2) == 0);
                PAR_EVEN: f.bits[k] = 1'((ones % 2) == 1);
                PAR_MARK: f.bits[k] = 1'b1;
                default:  f.bits[k] = 1'b0;
            endcase
            k++;
        end
        f.n = k + int'(sb);
        return f;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        frame_t q[$];
        frame_t cur;
        frame_t nf;
        bit     busy     = 1'b0;
        bit     gap      = 1'b0;
        bit     in_frame = 1'b0;
        int     idx      = 0;
        int     cnt      = 0;
        logic   exp_txd  = 1'b1;
        logic   exp_done = 1'b0;
        int     p_bits;

        is_uart_tx_fsm #(
            .PARITY_MODE (CFG_PAR[g]),
            .STOP_BITS   (CFG_STOP[g])
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .tx_ce_i      (ce),
            .tx_data_en_i (en),
            .tx_data_i    (data),
            .txd_o        (txd_w[g]),
            .txct_r_o     (rdy_w[g]),
            .tx_done_o    (done_w[g])
        );

        initial begin
            last_done_a[g] = -1;
            n_acc_a[g]     = 0;
            n_done_a[g]    = 0;
            p_bits         = (CFG_PAR[g] != PAR_NONE) ? 1 : 0;
        end

        // Model + monitor: inspects what the last rising edge sampled.
        always @(negedge clk) begin
            if (ce_q) cnt++;
            if (rst_q) begin
                q.delete();
                busy     = 1'b0;
                gap      = 1'b0;
                in_frame = 1'b0;
                exp_txd  = 1'b1;
                check(g, "reset_outputs", 32'({txd_w[g], rdy_w[g], done_w[g]}), 32'(3'b110));
            end else begin
                exp_done = 1'b0;
                if (gap) begin
                    gap = 1'b0;
                end else if (!busy && en_q) begin
                    busy     = 1'b1;
                    nf       = make_frame(data_q, CFG_PAR[g], CFG_STOP[g]);
                    nf.start = cnt + 1;
                    q.push_back(nf);
                    n_acc_a[g]++;
                end
                if (ce_q) begin
                    if (in_frame) begin
                        if (idx < cur.n) begin
                            exp_txd = cur.bits[idx];
                            idx++;
                        end else begin
                            exp_done = 1'b1;
                            exp_txd  = 1'b1;
                            in_frame = 1'b0;
                            busy     = 1'b0;
                            gap      = 1'b1;
                            n_done_a[g]++;
                            if (b2b_on && last_done_a[g] >= 0)
                                check(g, "b2b_period", 32'(cyc - last_done_a[g]),
                                      32'(12 + p_bits + int'(CFG_STOP[g])));
                            last_done_a[g] = cyc;
                        end
                    end else if (q.size() != 0 && q[0].start == cnt) begin
                        cur      = q.pop_front();
                        in_frame = 1'b1;
                        exp_txd  = cur.bits[0];
                        idx      = 1;
                    end
                end
                check(g, "txd",  32'(txd_w[g]),  32'(exp_txd));
                check(g, "done", 32'(done_w[g]), 32'(exp_done));
                check(g, "rdy",  32'(rdy_w[g]),  32'(!busy));
            end
            busy_a[g]   = busy;
            q_size_a[g] = q.size();
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b);
        en   = 1'b1;
        data = b;
        tick(1);
        en   = 1'b0;
    endtask

    initial begin
        bit found;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);

        // Basic frame and parity patterns at one strobe per 16 clocks.
        send(8'hA5);
        tick(260);
        send(8'h07);
        tick(260);

        // Second request while the first byte is still shifting out.
        send(8'h55);
        tick(64);
        send(8'h3C);
        tick(260);

        // Reset in the middle of a frame.
        send(8'h99);
        tick(80);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);

        // Request lands on the same cycle as a strobe.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (ce) found = 1'b1;
        end
        check(0, "ce_align", 32'(found), 32'(1));
        send(8'hC3);
        tick(260);

        // Back-to-back with strobe stuck high and request held.
        ce_mode = 1;
        tick(2);
        for (int i = 0; i < NI; i++) last_done_a[i] = -1;
        b2b_on = 1'b1;
        en     = 1'b1;
        for (int i = 0; i < 200; i++) begin
            data = 8'($urandom);
            tick(1);
        end
        en = 1'b0;
        tick(20);
        b2b_on = 1'b0;
        tick(10);

        // Random strobes, requests and one reset.
        ce_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            en   = ($urandom_range(19) == 0);
            data = 8'($urandom);
            rst  = (i >= 2000 && i < 2002);
            tick(1);
        end
        en      = 1'b0;
        rst     = 1'b0;
        ce_mode = 1;
        tick(40);

        for (int i = 0; i < NI; i++) begin
            check(i, "drain_busy",  32'(busy_a[i]),   32'(0));
            check(i, "drain_queue", 32'(q_size_a[i]), 32'(0));
        end
        check(0, "frames_sent", 32'(n_done_a[0]), 32'(n_acc_a[0] - 2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
